// File: rtl/up_counter_capture_if.sv
// Bundle of the counter-observer signals between a driver (master) and up_counter_capture (slave).
// The cap_wraps timestamp field exists only when UP_COUNTER_CAPTURE_TSTAMP_EN is defined.
interface up_counter_capture_if #(
    parameter int WIDTH = 4,
    parameter int CMP_W = 8
);
    logic [WIDTH-1:0] q_in;
    logic [WIDTH-1:0] cmp_val;
    logic             cap_req;
    logic             cap_ready;
    logic             stat_clr;
    logic [WIDTH-1:0] cap_data;
    logic             cap_valid;
    logic             wrap_pulse;
    logic             match_pulse;
    logic [CMP_W-1:0] wrap_cnt;
    logic             overrun;
`ifdef UP_COUNTER_CAPTURE_TSTAMP_EN
    logic [CMP_W-1:0] cap_wraps;
`endif

    modport master (
        output q_in, cmp_val, cap_req, cap_ready, stat_clr,
`ifdef UP_COUNTER_CAPTURE_TSTAMP_EN
        input  cap_wraps,
`endif
        input  cap_data, cap_valid, wrap_pulse, match_pulse, wrap_cnt, overrun
    );

    modport slave (
        input  q_in, cmp_val, cap_req, cap_ready, stat_clr,
`ifdef UP_COUNTER_CAPTURE_TSTAMP_EN
        output cap_wraps,
`endif
        output cap_data, cap_valid, wrap_pulse, match_pulse, wrap_cnt, overrun
    );
endinterface

// File: rtl/up_counter_capture.sv
// Observes a free-running up counter: wrap/match pulses, saturating wrap tally, and a
// valid/ready capture slot. Define UP_COUNTER_CAPTURE_TSTAMP_EN to add the cap_wraps timestamp.
module up_counter_capture #(
    parameter int WIDTH = 4,
    parameter int CMP_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    up_counter_capture_if.slave    bus
);
    localparam logic [WIDTH-1:0] Q_MAX   = {WIDTH{1'b1}};
    localparam logic [CMP_W-1:0] CNT_MAX = {CMP_W{1'b1}};
    localparam logic [CMP_W-1:0] CNT_ONE = {{(CMP_W-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_prev_q;
    logic [WIDTH-1:0] cap_data_q;
    logic             wrap_pulse_q;
    logic             match_pulse_q;
    logic [CMP_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic             overrun_q, overrun_d;
    logic             cap_load;
    logic             overrun_set;
    logic             wrap_evt;
    logic             match_evt;

    // q_prev starts at 0, so the first post-reset sample can never look like max->0.
    assign wrap_evt  = (q_prev_q == Q_MAX) && (bus.q_in == '0);
    assign match_evt = (bus.q_in == bus.cmp_val) && (bus.q_in != q_prev_q);

    always_comb begin
        state_d     = state_q;
        cap_load    = 1'b0;
        overrun_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.cap_req) begin
                    cap_load = 1'b1;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (bus.cap_ready) begin
                    cap_load = bus.cap_req;
                    state_d  = bus.cap_req ? HOLD : IDLE;
                end else if (bus.cap_req) begin
                    overrun_set = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wrap_cnt_d = wrap_cnt_q;
        if (bus.stat_clr)
            wrap_cnt_d = '0;
        else if (wrap_evt && (wrap_cnt_q != CNT_MAX))
            wrap_cnt_d = wrap_cnt_q + CNT_ONE;
    end

    // A fresh drop outranks a coincident clear so no overrun is ever lost.
    always_comb begin
        overrun_d = overrun_q;
        if (overrun_set)
            overrun_d = 1'b1;
        else if (bus.stat_clr)
            overrun_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            q_prev_q      <= '0;
            cap_data_q    <= '0;
            wrap_pulse_q  <= 1'b0;
            match_pulse_q <= 1'b0;
            wrap_cnt_q    <= '0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            q_prev_q      <= bus.q_in;
            wrap_pulse_q  <= wrap_evt;
            match_pulse_q <= match_evt;
            wrap_cnt_q    <= wrap_cnt_d;
            overrun_q     <= overrun_d;
            if (cap_load)
                cap_data_q <= bus.q_in;
        end
    end

`ifdef UP_COUNTER_CAPTURE_TSTAMP_EN
    logic [CMP_W-1:0] cap_wraps_q;

    // Loads the pre-increment tally, so a wrap on the capture edge is not yet counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cap_wraps_q <= '0;
        else if (cap_load)
            cap_wraps_q <= wrap_cnt_q;
    end

    assign bus.cap_wraps = cap_wraps_q;
`endif

    assign bus.cap_data    = cap_data_q;
    assign bus.cap_valid   = (state_q == HOLD);
    assign bus.wrap_pulse  = wrap_pulse_q;
    assign bus.match_pulse = match_pulse_q;
    assign bus.wrap_cnt    = wrap_cnt_q;
    assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_up_counter_capture.sv
// Directed test-plan steps followed by random traffic, checked every cycle against a
// transaction-level model (capture slot kept as a one-deep queue).
module tb_up_counter_capture;
    localparam int WIDTH = 4;
    localparam int CMP_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    up_counter_capture_if #(.WIDTH(WIDTH), .CMP_W(CMP_W)) bus ();

    up_counter_capture #(.WIDTH(WIDTH), .CMP_W(CMP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic [CMP_W-1:0] w;
    } cap_t;

    cap_t m_slot[$];
    int   m_prev, m_wraps, m_wrap_p, m_match_p, m_overrun, m_last_d, m_last_w;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_slot.delete();
        m_prev = 0; m_wraps = 0; m_wrap_p = 0; m_match_p = 0;
        m_overrun = 0; m_last_d = 0; m_last_w = 0;
    endtask

    // Applies one clock edge's worth of the rules to the model, using the inputs seen at the edge.
    task automatic model_edge();
        int   q, cmp;
        bit   wrap, dropped;
        cap_t c;
        q   = int'(bus.q_in);
        cmp = int'(bus.cmp_val);
        wrap    = (m_prev == (1 << WIDTH) - 1) && (q == 0);
        dropped = 1'b0;
        c.d = q[WIDTH-1:0];
        c.w = m_wraps[CMP_W-1:0];
        if (m_slot.size() == 0) begin
            if (bus.cap_req) m_slot.push_back(c);
        end else if (bus.cap_ready) begin
            cap_t done;
            done = m_slot.pop_front();
            $display("xfer data=%0d wraps=%0d t=%0t", done.d, done.w, $time);
            if (bus.cap_req) m_slot.push_back(c);
        end else if (bus.cap_req) begin
            dropped = 1'b1;
        end
        if (bus.cap_req && (m_slot.size() != 0) && (m_slot[0] == c) && !dropped) begin
            m_last_d = q;
            m_last_w = m_wraps;
        end
        if (dropped)            m_overrun = 1;
        else if (bus.stat_clr)  m_overrun = 0;
        if (bus.stat_clr)       m_wraps = 0;
        else if (wrap)          m_wraps = (m_wraps + 1 > (1 << CMP_W) - 1) ? (1 << CMP_W) - 1 : m_wraps + 1;
        m_wrap_p  = wrap ? 1 : 0;
        m_match_p = ((q == cmp) && (q != m_prev)) ? 1 : 0;
        m_prev    = q;
    endtask

    task automatic check_outputs();
        check("wrap_pulse",  32'(bus.wrap_pulse),  32'(m_wrap_p));
        check("match_pulse", 32'(bus.match_pulse), 32'(m_match_p));
        check("wrap_cnt",    32'(bus.wrap_cnt),    32'(m_wraps));
        check("overrun",     32'(bus.overrun),     32'(m_overrun));
        check("cap_valid",   32'(bus.cap_valid),   32'(m_slot.size() != 0));
        check("cap_data",    32'(bus.cap_data),    32'(m_last_d));
`ifdef UP_COUNTER_CAPTURE_TSTAMP_EN
        check("cap_wraps",   32'(bus.cap_wraps),   32'(m_last_w));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drive(input int q, input bit req, input bit rdy, input bit clr);
        bus.q_in      = q[WIDTH-1:0];
        bus.cap_req   = req;
        bus.cap_ready = rdy;
        bus.stat_clr  = clr;
        step();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cap_valid"}, 32'(bus.cap_valid),   32'd0);
        check({tag, "_cap_data"},  32'(bus.cap_data),    32'd0);
        check({tag, "_wrap_cnt"},  32'(bus.wrap_cnt),    32'd0);
        check({tag, "_overrun"},   32'(bus.overrun),     32'd0);
        check({tag, "_wrap_p"},    32'(bus.wrap_pulse),  32'd0);
        check({tag, "_match_p"},   32'(bus.match_pulse), 32'd0);
    endtask

    initial begin
        int pulses, vcount, q;
        bus.q_in = '0; bus.cmp_val = 4'd9; bus.cap_req = 1'b0;
        bus.cap_ready = 1'b0; bus.stat_clr = 1'b0;
        model_reset();
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Free-run 0..15,0,1: exactly one wrap pulse, tally 1, nothing at reset release.
        pulses = 0;
        for (int i = 0; i < 18; i++) begin
            drive(i % 16, 0, 0, 0);
            pulses += int'(bus.wrap_pulse);
        end
        check("freerun_wrap_pulses", 32'(pulses), 32'd1);
        check("freerun_wrap_cnt", 32'(bus.wrap_cnt), 32'd1);

        // Park at 5, move cmp onto it (no pulse), hold, then two passes through 5.
        bus.cmp_val = 4'd0;
        drive(5, 0, 0, 0);
        bus.cmp_val = 4'd5;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            drive(5, 0, 0, 0);
            pulses += int'(bus.match_pulse);
        end
        for (int i = 0; i < 32; i++) begin
            drive((6 + i) % 16, 0, 0, 0);
            pulses += int'(bus.match_pulse);
        end
        check("match_pulses", 32'(pulses), 32'd2);

        // Capture at 3 held for 5 cycles, overrun at 7, back-to-back recapture at 9.
        drive(3, 1, 0, 0);
        vcount = int'(bus.cap_valid);
        for (int i = 0; i < 3; i++) begin
            drive(4 + i, 0, 0, 0);
            vcount += int'(bus.cap_valid);
        end
        drive(7, 1, 0, 0);
        vcount += int'(bus.cap_valid);
        check("hold_valid_cycles", 32'(vcount), 32'd5);
        check("overrun_set", 32'(bus.overrun), 32'd1);
        check("hold_data", 32'(bus.cap_data), 32'd3);
        drive(9, 1, 1, 0);
        check("b2b_valid", 32'(bus.cap_valid), 32'd1);
        check("b2b_data", 32'(bus.cap_data), 32'd9);
        drive(10, 0, 1, 0);
        check("xfer_valid_low", 32'(bus.cap_valid), 32'd0);
        drive(11, 0, 0, 1);
        check("overrun_clr", 32'(bus.overrun), 32'd0);

        // 300 wraps saturate the tally; clear coincident with a wrap wins.
        for (int i = 0; i < 300; i++) begin
            drive(15, 0, 0, 0);
            drive(0, 0, 0, 0);
        end
        check("wrap_sat", 32'(bus.wrap_cnt), 32'd255);
        drive(15, 0, 0, 0);
        drive(0, 0, 0, 1);
        check("clr_vs_wrap", 32'(bus.wrap_cnt), 32'd0);

        // Build HOLD with 12 wraps and overrun, then reset mid-cycle.
        for (int i = 0; i < 12; i++) begin
            drive(15, 0, 0, 0);
            drive(0, 0, 0, 0);
        end
        drive(2, 1, 0, 0);
        drive(4, 1, 0, 0);
        check("pre_rst_wrap_cnt", 32'(bus.wrap_cnt), 32'd12);
        check("pre_rst_overrun", 32'(bus.overrun), 32'd1);
        check("pre_rst_valid", 32'(bus.cap_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(6, 1, 0, 0);
        check("post_rst_valid", 32'(bus.cap_valid), 32'd1);
        check("post_rst_data", 32'(bus.cap_data), 32'd6);
        drive(7, 0, 1, 0);

        // Random traffic: mostly counting, with holds, jumps, cmp changes and clears.
        q = 7;
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 70)      q = (q + 1) % 16;
            else if (r < 85) q = int'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) bus.cmp_val = 4'($urandom_range(0, 15));
            drive(q, $urandom_range(0, 9) < 3, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 19) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/up_counter_capture.md
Name: up_counter_capture

Overview:
- Downstream consumer of the 4-bit synchronous up counter output `q`.
- Samples the count every cycle and flags wrap-around (max->0) and compare-match events.
- Keeps a saturating wrap tally.
- Snapshots the count on request, presented via a valid/ready handshake to a register-readout or logging stage.

Parameters:
- WIDTH, 4, counter width; q_in and cap_data width.
- CMP_W, 8, wrap_cnt width (saturating).

Ports:
- clk  input  1  rising-edge clock, same clock as the counter.
- rst  input  1  asynchronous, active-high reset.
- q_in  input  WIDTH  counter value (counter `q`).
- cmp_val  input  WIDTH  compare value, static or changed at any time.
- cap_req  input  1  capture request, level sampled each cycle.
- cap_ready  input  1  consumer accepts cap_data.
- stat_clr  input  1  synchronous clear of wrap_cnt and overrun.
- cap_data  output  WIDTH  captured count.
- cap_valid  output  1  cap_data holds an unconsumed capture.
- wrap_pulse  output  1  one-cycle pulse per wrap.
- match_pulse  output  1  one-cycle pulse on entry into q_in==cmp_val.
- wrap_cnt  output  CMP_W  saturating wrap count.
- overrun  output  1  sticky; a request was dropped.

Behaviour:
- Interface decided: single clock `clk`; reset `rst` asynchronous, active-high. All flops reset asynchronously; logic is synchronous to the rising edge of clk.
- Reset values: q_prev=0, cap_data=0, cap_valid=0, wrap_pulse=0, match_pulse=0, wrap_cnt=0, overrun=0, FSM=IDLE.
- q_prev register samples q_in every cycle.
- Wrap:
  - wrap_pulse registered.
  - Asserted the cycle after the edge where q_prev==2^WIDTH-1 and q_in==0; latency 1.
  - No wrap is reported on the first sample after reset (q_prev=0).
  - A jump to 0 from any value other than max is not a wrap.
- Match:
  - match_pulse registered.
  - Asserted the cycle after the edge where q_in==cmp_val and q_in!=q_prev.
  - A held count produces exactly one pulse.
  - A cmp_val change onto the current held value produces no pulse.
- wrap_cnt:
  - Increments on each wrap event (same edge that sets wrap_pulse).
  - Saturates at 2^CMP_W-1.
  - stat_clr has priority: a simultaneous clr and wrap gives 0.
- Capture FSM, IDLE / HOLD:
  - IDLE: cap_req=1 -> cap_data<=q_in (current-cycle value), cap_valid<=1, go HOLD.
  - HOLD: cap_valid=1, cap_data stable.
  - HOLD, cap_ready=1 and cap_req=0 -> transfer; cap_valid<=0, go IDLE.
  - HOLD, cap_ready=1 and cap_req=1 -> transfer plus recapture of q_in; stay HOLD, cap_valid stays 1 (back-to-back, no bubble).
  - HOLD, cap_ready=0 and cap_req=1 -> request dropped, overrun<=1, cap_data unchanged.
  - cap_ready in IDLE is ignored.
- overrun: sticky until stat_clr or rst. If stat_clr and a new overrun occur in the same cycle, overrun is set to 1 (set wins).
- Reset mid-HOLD discards the capture immediately: cap_valid drops asynchronously.
- Width rule: all compares are unsigned over WIDTH bits; no arithmetic on q_in.

Optional Feature:
- Macro: UP_COUNTER_CAPTURE_TSTAMP_EN.
- Defined:
  - Adds output `cap_wraps [CMP_W-1:0]`, loaded with wrap_cnt on every capture (IDLE capture and HOLD recapture). If a wrap occurs on the capture edge, the pre-increment wrap_cnt value is loaded.
  - Together with cap_data this forms an extended timestamp.
  - Reset value 0; held stable in HOLD like cap_data.
- Undefined: port and register absent; all other behaviour identical.

Test Plan:
- Reset then free-run counter 0..15,0: wrap_pulse=1 for exactly one cycle, one cycle after q_in=0 is sampled; wrap_cnt=1; no wrap_pulse at reset release.
- cmp_val=5, counter held at 5 for 3 cycles, then normal counting for 2 passes: match_pulse asserted once per pass, not during the hold; total 2 pulses.
- cap_req 1 cycle at q_in=3, cap_ready low for 4 cycles then high 1 cycle: cap_data=3, cap_valid=1 for 5 cycles, then 0 the next cycle; with macro, cap_wraps equals wrap_cnt at the request.
- In HOLD with cap_data=3, cap_req at q_in=7 with cap_ready=0: overrun=1, cap_data stays 3. Then cap_req+cap_ready at q_in=9: cap_valid stays 1, cap_data=9. Then stat_clr: overrun=0.
- Force 300 wraps: wrap_cnt=255 and holds. Then stat_clr coincident with a wrap: wrap_cnt=0.
- Assert rst mid-HOLD (cap_valid=1, wrap_cnt=12, overrun=1): all outputs 0 immediately, before the next clk edge; after release, FSM=IDLE and the first cap_req captures normally.
